// File: rtl/srdl2sv_ext_reg_bridge_if.sv
`default_nettype none
// ============================================================================
// Module  : srdl2sv_ext_reg_bridge_if
// Brief   : Register-bus request/response bundle for the external register bridge.
// Revision: 1.0
// ============================================================================
interface srdl2sv_ext_reg_bridge_if #(
    parameter int BUS_BITS = 32
);
    typedef struct packed {
        logic [31:0]           addr;
        logic [BUS_BITS-1:0]   data;
        logic [BUS_BITS/8-1:0] byte_en;
        logic                  w_vld;
        logic                  r_vld;
    } b2r_t;

    typedef struct packed {
        logic [BUS_BITS-1:0] data;
        logic                rdy;
        logic                err;
    } r2b_t;

    b2r_t b2r;
    r2b_t r2b;

    modport slave  (input b2r, output r2b);
    modport master (output b2r, input r2b);
endinterface
`default_nettype wire

// File: rtl/srdl2sv_ext_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module  : srdl2sv_ext_reg_bridge
// Brief   : Forwards one register access at a time to an external target window.
// Revision: 1.0
// ============================================================================
module srdl2sv_ext_reg_bridge #(
    parameter int          BUS_BITS       = 32,
    parameter logic [31:0] ADDR_BASE      = 32'h0,
    parameter logic [31:0] ADDR_SIZE      = 32'h100,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  wire logic                  HCLK,
    input  wire logic                  HRESETn,
    srdl2sv_ext_reg_bridge_if.slave    bus,
    output logic                       ext_req,
    output logic                       ext_we,
    output logic [31:0]                ext_addr,
    output logic [BUS_BITS-1:0]        ext_wdata,
    output logic [BUS_BITS/8-1:0]      ext_byte_en,
    input  wire logic                  ext_ack,
    input  wire logic                  ext_err,
    input  wire logic [BUS_BITS-1:0]   ext_rdata,
    output logic                       timeout_evt,
    output logic                       busy
);
    localparam int BE_BITS  = BUS_BITS / 8;
    localparam int CNT_BITS = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_BITS-1:0] C_CNT_LAST =
        CNT_BITS'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    // Window bounds in 33 bits so a window touching 2^32 cannot wrap.
    localparam logic [32:0] C_WIN_LO = {1'b0, ADDR_BASE};
    localparam logic [32:0] C_WIN_HI = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_accept;
    logic                  w_in_win;
    logic                  w_tmo;
    logic [CNT_BITS-1:0]   r_cnt;
    logic                  r_resp_err;
    logic [BUS_BITS-1:0]   r_resp_data;
    logic                  r_we;
    logic [31:0]           r_addr;
    logic [BUS_BITS-1:0]   r_wdata;
    logic [BE_BITS-1:0]    r_be;

    assign w_in_win = ({1'b0, bus.b2r.addr} >= C_WIN_LO) && ({1'b0, bus.b2r.addr} < C_WIN_HI);
    assign w_tmo    = (TIMEOUT_CYCLES != 0) && (r_cnt == C_CNT_LAST) && !ext_ack;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        ext_req     = 1'b0;
        timeout_evt = 1'b0;
        busy        = 1'b1;
        bus.r2b     = '0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (bus.b2r.w_vld && bus.b2r.r_vld) begin
                    w_next = ERR;
                end else if (bus.b2r.w_vld || bus.b2r.r_vld) begin
                    if (w_in_win) begin
                        w_accept = 1'b1;
                        w_next   = REQ;
                    end else begin
                        w_next = ERR;
                    end
                end
            end
            REQ: begin
                ext_req = 1'b1;
                if (ext_ack) begin
                    w_next = RESP;
                end else if (w_tmo) begin
                    timeout_evt = 1'b1;
                    w_next      = ERR;
                end
            end
            RESP: begin
                bus.r2b.rdy  = 1'b1;
                bus.r2b.err  = r_resp_err;
                bus.r2b.data = r_resp_data;
                w_next       = IDLE;
            end
            default: begin
                bus.r2b.rdy = 1'b1;
                bus.r2b.err = 1'b1;
                w_next      = IDLE;
            end
        endcase
    end

    // Wait counter idles at zero so it always starts from zero on REQ entry.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_cnt       <= '0;
            r_resp_err  <= 1'b0;
            r_resp_data <= '0;
        end else if (r_state == REQ) begin
            if (ext_ack) begin
                r_resp_err  <= ext_err;
                r_resp_data <= r_we ? '0 : ext_rdata;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (w_accept) begin
            r_we    <= bus.b2r.w_vld;
            r_addr  <= bus.b2r.addr - ADDR_BASE;
            r_wdata <= bus.b2r.data;
            r_be    <= bus.b2r.byte_en;
        end
    end

    assign ext_we      = r_we;
    assign ext_addr    = r_addr;
    assign ext_wdata   = r_wdata;
    assign ext_byte_en = r_be;
endmodule
`default_nettype wire

// File: tb/tb_srdl2sv_ext_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_srdl2sv_ext_reg_bridge
// Brief   : Directed self-checking bench for the external register bridge.
// Revision: 1.0
// ============================================================================
module tb_srdl2sv_ext_reg_bridge;
    localparam int BUS_BITS = 32;

    logic                HCLK = 1'b0;
    logic                HRESETn;
    logic                ext_req;
    logic                ext_we;
    logic [31:0]         ext_addr;
    logic [BUS_BITS-1:0] ext_wdata;
    logic [3:0]          ext_byte_en;
    logic                ext_ack;
    logic                ext_err;
    logic [BUS_BITS-1:0] ext_rdata;
    logic                timeout_evt;
    logic                busy;

    int n_checks = 0;
    int n_fail   = 0;

    srdl2sv_ext_reg_bridge_if #(.BUS_BITS(BUS_BITS)) bif ();

    srdl2sv_ext_reg_bridge #(
        .BUS_BITS      (BUS_BITS),
        .ADDR_BASE     (32'h1000),
        .ADDR_SIZE     (32'h100),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .bus        (bif.slave),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_byte_en(ext_byte_en),
        .ext_ack    (ext_ack),
        .ext_err    (ext_err),
        .ext_rdata  (ext_rdata),
        .timeout_evt(timeout_evt),
        .busy       (busy)
    );

    always #5 HCLK = ~HCLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_idle();
        bif.b2r = '0;
        ext_ack = 1'b0;
        ext_err = 1'b0;
    endtask

    task automatic start(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be);
        bif.b2r.addr    = addr;
        bif.b2r.data    = data;
        bif.b2r.byte_en = be;
        bif.b2r.w_vld   = wr;
        bif.b2r.r_vld   = !wr;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_rdy"},  64'(bif.r2b.rdy), 64'd0);
        check_eq({tag, "_req"},  64'(ext_req), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        HRESETn   = 1'b0;
        ext_rdata = '0;
        bus_idle();
        #2;
        check_eq("rst_req",  64'(ext_req), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_rdy",  64'(bif.r2b.rdy), 64'd0);
        check_eq("rst_err",  64'(bif.r2b.err), 64'd0);
        check_eq("rst_tmo",  64'(timeout_evt), 64'd0);
        check_eq("rst_data", 64'(bif.r2b.data), 64'd0);
        tick();
        tick();
        HRESETn = 1'b1;
        tick();

        // Read at 0x1004, ack in the first REQ cycle.
        start(1'b0, 32'h1004, 32'h0, 4'hF);
        tick();
        check_eq("rd_req",  64'(ext_req), 64'd1);
        check_eq("rd_we",   64'(ext_we), 64'd0);
        check_eq("rd_addr", 64'(ext_addr), 64'h4);
        check_eq("rd_busy", 64'(busy), 64'd1);
        check_eq("rd_rdy0", 64'(bif.r2b.rdy), 64'd0);
        bus_idle();
        ext_ack   = 1'b1;
        ext_rdata = 32'hDEADBEEF;
        tick();
        ext_ack = 1'b0;
        check_eq("rd_rdy",   64'(bif.r2b.rdy), 64'd1);
        check_eq("rd_err",   64'(bif.r2b.err), 64'd0);
        check_eq("rd_data",  64'(bif.r2b.data), 64'hDEADBEEF);
        check_eq("rd_req_off", 64'(ext_req), 64'd0);
        tick();
        check_quiet("rd_done");

        // Stray ack/err outside REQ must not disturb anything.
        ext_ack = 1'b1;
        ext_err = 1'b1;
        tick();
        check_quiet("stray");
        bus_idle();

        // Write with three wait cycles; ack on 4th REQ cycle coincides with the timeout point.
        start(1'b1, 32'h1010, 32'h12345678, 4'b0011);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) bus_idle();
            check_eq($sformatf("wr_req%0d", i),   64'(ext_req), 64'd1);
            check_eq($sformatf("wr_we%0d", i),    64'(ext_we), 64'd1);
            check_eq($sformatf("wr_addr%0d", i),  64'(ext_addr), 64'h10);
            check_eq($sformatf("wr_wdata%0d", i), 64'(ext_wdata), 64'h12345678);
            check_eq($sformatf("wr_be%0d", i),    64'(ext_byte_en), 64'h3);
            check_eq($sformatf("wr_rdy%0d", i),   64'(bif.r2b.rdy), 64'd0);
            if (i == 3) begin
                ext_ack   = 1'b1;
                ext_rdata = 32'hFFFF0000;
                #1;
                check_eq("wr_tmo_ack_wins", 64'(timeout_evt), 64'd0);
            end
        end
        tick();
        ext_ack = 1'b0;
        check_eq("wr_rdy",  64'(bif.r2b.rdy), 64'd1);
        check_eq("wr_err",  64'(bif.r2b.err), 64'd0);
        check_eq("wr_data", 64'(bif.r2b.data), 64'd0);
        check_eq("wr_tmo",  64'(timeout_evt), 64'd0);
        tick();

        // Out-of-window addresses, just above and far above, and both vld set.
        for (int k = 0; k < 3; k++) begin
            if (k == 0) start(1'b0, 32'h2000, 32'h0, 4'hF);
            if (k == 1) start(1'b1, 32'h1100, 32'hAA, 4'hF);
            if (k == 2) begin
                start(1'b1, 32'h1000, 32'hAA, 4'hF);
                bif.b2r.r_vld = 1'b1;
            end
            tick();
            bus_idle();
            check_eq($sformatf("oow%0d_req", k),  64'(ext_req), 64'd0);
            check_eq($sformatf("oow%0d_rdy", k),  64'(bif.r2b.rdy), 64'd1);
            check_eq($sformatf("oow%0d_err", k),  64'(bif.r2b.err), 64'd1);
            check_eq($sformatf("oow%0d_data", k), 64'(bif.r2b.data), 64'd0);
            tick();
            check_quiet($sformatf("oow%0d_done", k));
        end

        // Timeout: last in-window word, no ack ever.
        start(1'b0, 32'h10FC, 32'h0, 4'hF);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) bus_idle();
            check_eq($sformatf("to_req%0d", i),  64'(ext_req), 64'd1);
            check_eq($sformatf("to_evt%0d", i),  64'(timeout_evt), (i == 3) ? 64'd1 : 64'd0);
        end
        check_eq("to_addr", 64'(ext_addr), 64'hFC);
        tick();
        check_eq("to_req_off", 64'(ext_req), 64'd0);
        check_eq("to_evt_off", 64'(timeout_evt), 64'd0);
        check_eq("to_rdy", 64'(bif.r2b.rdy), 64'd1);
        check_eq("to_err", 64'(bif.r2b.err), 64'd1);
        tick();
        check_quiet("to_done");

        // Read with target error, vld held high, then back-to-back write.
        start(1'b0, 32'h1020, 32'h0, 4'hF);
        tick();
        ext_ack   = 1'b1;
        ext_err   = 1'b1;
        ext_rdata = 32'hCAFE0001;
        tick();
        ext_ack = 1'b0;
        ext_err = 1'b0;
        check_eq("er_rdy",  64'(bif.r2b.rdy), 64'd1);
        check_eq("er_err",  64'(bif.r2b.err), 64'd1);
        check_eq("er_data", 64'(bif.r2b.data), 64'hCAFE0001);
        start(1'b1, 32'h1024, 32'h55, 4'h1);
        tick();
        check_eq("b2b_idle_rdy",  64'(bif.r2b.rdy), 64'd0);
        check_eq("b2b_idle_busy", 64'(busy), 64'd0);
        tick();
        bus_idle();
        check_eq("b2b_req",  64'(ext_req), 64'd1);
        check_eq("b2b_addr", 64'(ext_addr), 64'h24);
        check_eq("b2b_we",   64'(ext_we), 64'd1);
        ext_ack = 1'b1;
        tick();
        ext_ack = 1'b0;
        check_eq("b2b_rdy", 64'(bif.r2b.rdy), 64'd1);
        check_eq("b2b_err", 64'(bif.r2b.err), 64'd0);
        tick();
        check_eq("b2b_rdy_once", 64'(bif.r2b.rdy), 64'd0);

        // Asynchronous reset while in REQ.
        start(1'b0, 32'h1030, 32'h0, 4'hF);
        tick();
        bus_idle();
        check_eq("ar_req_pre", 64'(ext_req), 64'd1);
        #2 HRESETn = 1'b0;
        #1;
        check_eq("ar_req",  64'(ext_req), 64'd0);
        check_eq("ar_busy", 64'(busy), 64'd0);
        check_eq("ar_rdy",  64'(bif.r2b.rdy), 64'd0);
        #2 HRESETn = 1'b1;
        tick();
        check_quiet("ar_post");
        start(1'b0, 32'h1008, 32'h0, 4'hF);
        tick();
        bus_idle();
        check_eq("ar2_addr", 64'(ext_addr), 64'h8);
        ext_ack   = 1'b1;
        ext_rdata = 32'h0BADF00D;
        tick();
        ext_ack = 1'b0;
        check_eq("ar2_rdy",  64'(bif.r2b.rdy), 64'd1);
        check_eq("ar2_err",  64'(bif.r2b.err), 64'd0);
        check_eq("ar2_data", 64'(bif.r2b.data), 64'h0BADF00D);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/srdl2sv_ext_reg_bridge.md
SRDL2SV_EXT_REG_BRIDGE -- requirements
Module: srdl2sv_ext_reg_bridge

Interface
REQ-001 SHALL have parameter BUS_BITS, default 32, meaning data width of b2r/r2b and external port (multiple of 8).
REQ-002 SHALL have parameter ADDR_BASE, default 32'h0, meaning first byte address of the external window.
REQ-003 SHALL have parameter ADDR_SIZE, default 32'h100, meaning window size in bytes (power of two, at least BUS_BITS/8).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning maximum REQ cycles without ext_ack; 0 disables the timeout.
REQ-005 SHALL have port HCLK, input, 1, meaning clock.
REQ-006 SHALL have port HRESETn, input, 1, meaning reset, asynchronous, active-low.
REQ-007 SHALL have port b2r, input, b2r_t, meaning fields addr[31:0], data[BUS_BITS-1:0], byte_en[BUS_BITS/8-1:0], w_vld, r_vld from the bus slave.
REQ-008 SHALL have port r2b, output, r2b_t, meaning fields data[BUS_BITS-1:0], rdy, err to the bus slave.
REQ-009 SHALL have port ext_req, output, 1, meaning external access request.
REQ-010 SHALL have port ext_we, output, 1, meaning 1 = write, 0 = read.
REQ-011 SHALL have port ext_addr, output, 32, meaning window-relative byte address (b2r.addr - ADDR_BASE).
REQ-012 SHALL have port ext_wdata, output, BUS_BITS, meaning write data.
REQ-013 SHALL have port ext_byte_en, output, BUS_BITS/8, meaning byte enables.
REQ-014 SHALL have ports ext_ack (in, 1), ext_err (in, 1) and ext_rdata (in, BUS_BITS), meaning target completion, target error and read data, all sampled only when ext_ack=1.
REQ-015 SHALL have port timeout_evt, output, 1, meaning single-cycle pulse on timeout.
REQ-016 SHALL have port busy, output, 1, meaning FSM not in IDLE.

Function
REQ-017 FSM states SHALL be IDLE, REQ, RESP and ERR, all registered.
REQ-018 In IDLE, when w_vld and r_vld are both 1, next state SHALL be ERR, as a protocol violation.
REQ-019 In IDLE, when exactly one vld is set and ADDR_BASE <= addr < ADDR_BASE+ADDR_SIZE (32-bit unsigned, no wrap), the block SHALL capture addr-ADDR_BASE, data, byte_en and we=w_vld, then go to REQ.
REQ-020 In IDLE, when exactly one vld is set and addr is out of window, next state SHALL be ERR, with no ext_req issued.
REQ-021 In REQ, ext_req SHALL be 1 and ext_we, ext_addr, ext_wdata and ext_byte_en SHALL hold the captured values stable until the cycle ext_ack=1.
REQ-022 In REQ, ext_ack=1 SHALL capture ext_err into resp_err and, for reads only, ext_rdata into resp_data, then go to RESP.
REQ-023 In REQ, ext_req SHALL be 0 in the cycle after ext_ack.
REQ-024 For writes, resp_data SHALL be 0.
REQ-025 In REQ, a wait counter SHALL start at 0 on entry and increment each REQ cycle without ack; counter width SHALL be $clog2(TIMEOUT_CYCLES+1).
REQ-026 When TIMEOUT_CYCLES != 0 and the counter equals TIMEOUT_CYCLES-1 with ext_ack=0, the block SHALL pulse timeout_evt, deassert ext_req next cycle, and go to ERR.
REQ-027 When ext_ack=1 and the timeout condition coincide, ack SHALL win and no timeout_evt SHALL be raised.
REQ-028 In RESP, r2b.rdy SHALL be 1, r2b.err SHALL equal resp_err, r2b.data SHALL equal resp_data, and next state SHALL be IDLE.
REQ-029 In ERR, r2b.rdy SHALL be 1, r2b.err SHALL be 1, r2b.data SHALL be 0, and next state SHALL be IDLE.
REQ-030 In IDLE and REQ, r2b.rdy, r2b.err and r2b.data SHALL be 0.
REQ-031 r2b.rdy SHALL be exactly one cycle per accepted access; vld still high in RESP/ERR SHALL NOT be re-accepted, and vld seen in IDLE the following cycle SHALL be treated as a new access.
REQ-032 Latency SHALL be rdy 2 cycles after vld when ext_ack arrives in the first REQ cycle (IDLE@N, REQ@N+1, RESP@N+2), plus one per wait cycle; error paths SHALL give rdy 1 cycle after vld.
REQ-033 ext_ack, ext_err and ext_rdata SHALL be ignored outside REQ.
REQ-034 busy SHALL be 1 in every state except IDLE.

Reset
REQ-035 HRESETn low SHALL asynchronously force state IDLE, counter 0, resp_err 0 and resp_data 0.
REQ-036 During reset, ext_req, timeout_evt, busy, r2b.rdy and r2b.err SHALL be 0 immediately, including mid-access (no completion reported).
REQ-037 Captured payload registers SHALL need no reset.

Verification
REQ-038 Read with ADDR_BASE=0x1000, addr=0x1004, ext_ack in the first REQ cycle, ext_rdata=0xDEADBEEF -> ext_addr=0x4, ext_we=0, r2b.rdy@N+2 with data 0xDEADBEEF, err 0.
REQ-039 Write data=0x12345678, byte_en=4'b0011, ext_ack after 3 wait cycles -> ext_req high 4 cycles with stable payload; rdy@N+5, err 0, data 0.
REQ-040 addr=0x2000 (out of window) -> no ext_req; rdy=1, err=1 at N+1.
REQ-041 TIMEOUT_CYCLES=4, no ext_ack -> ext_req high 4 cycles, timeout_evt single pulse, then rdy=1/err=1; a second case with ext_ack on the 4th REQ cycle -> normal RESP, no timeout_evt.
REQ-042 Read with ext_ack=1 and ext_err=1 -> rdy with err=1; back-to-back vld immediately after rdy -> second access accepted, exactly one rdy each.
REQ-043 HRESETn asserted while in REQ -> ext_req and busy drop asynchronously; after release a new access completes normally.
